// File: rtl/seq_stream_sched_pkg.sv
// Shared types and default sizing for the round-robin serialiser in front of the bit-sequence detector.
package seq_sched_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} sched_state_t;

    localparam int WORD_W_DEF     = 10;
    localparam int GAP_CYCLES_DEF = 3;

endpackage

// File: rtl/seq_stream_sched_if.sv
// Requester handshake, serial detector feed and status bundle; DET_IN/DET_COUNT exist only with SEQ_SCHED_DET_COUNT_EN.
interface seq_stream_sched_if #(
    parameter int N_REQ  = 2,
    parameter int WORD_W = 10
);
    localparam int IW   = $clog2(N_REQ);
    localparam int DC_W = $clog2(WORD_W + 2);

    logic [N_REQ-1:0]        REQ_VALID;
    logic [N_REQ*WORD_W-1:0] REQ_WORD;
    logic [N_REQ-1:0]        REQ_READY;
    logic                    ABORT;
    logic                    DATA;
    logic                    DATA_VALID;
    logic [IW-1:0]           GRANT_ID;
    logic                    BUSY;
    logic                    WORD_DONE;
`ifdef SEQ_SCHED_DET_COUNT_EN
    logic                    DET_IN;
    logic [DC_W-1:0]         DET_COUNT;

    modport master (output REQ_VALID, REQ_WORD, ABORT, DET_IN,
                    input  REQ_READY, DATA, DATA_VALID, GRANT_ID, BUSY, WORD_DONE, DET_COUNT);
    modport slave  (input  REQ_VALID, REQ_WORD, ABORT, DET_IN,
                    output REQ_READY, DATA, DATA_VALID, GRANT_ID, BUSY, WORD_DONE, DET_COUNT);
`else
    modport master (output REQ_VALID, REQ_WORD, ABORT,
                    input  REQ_READY, DATA, DATA_VALID, GRANT_ID, BUSY, WORD_DONE);
    modport slave  (input  REQ_VALID, REQ_WORD, ABORT,
                    output REQ_READY, DATA, DATA_VALID, GRANT_ID, BUSY, WORD_DONE);
`endif
endinterface

// File: rtl/seq_stream_sched_arb.sv
// Combinational round-robin pick: first valid request searching upward from i_ptr+1 with wrap-around.
// Zero latency; o_any low and o_gnt zero when nothing is requesting.
module rr_arbiter_comb #(
    parameter int N_REQ = 2,
    parameter int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_vld,
    input  logic [IW-1:0]    i_ptr,
    output logic [N_REQ-1:0] o_gnt,
    output logic [IW-1:0]    o_idx,
    output logic             o_any
);
    int unsigned w_pos;

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_pos = 0;
        for (int off = 1; off <= N_REQ; off++) begin
            w_pos = (32'(i_ptr) + 32'(off)) % 32'(N_REQ);
            if (!o_any && i_vld[w_pos]) begin
                o_any        = 1'b1;
                o_idx        = IW'(w_pos);
                o_gnt[w_pos] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/seq_stream_sched.sv
// Round-robin scheduler serialising requester words LSB-first onto the detector's DATA input, then an idle gap.
// One accept per IDLE cycle (REQ_READY combinational); optional detector hit counter under SEQ_SCHED_DET_COUNT_EN.
module seq_stream_sched
    import seq_sched_pkg::*;
#(
    parameter int WORD_W     = WORD_W_DEF,
    parameter int N_REQ      = 2,
    parameter int GAP_CYCLES = GAP_CYCLES_DEF
) (
    input  logic               CLK,
    input  logic               RST,
    seq_stream_sched_if.slave  bus
);
    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(WORD_W);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    sched_state_t      r_state;
    logic [WORD_W-1:0] r_shreg;
    logic [CW-1:0]     r_cnt;
    logic [GW-1:0]     r_gap;
    logic [IW-1:0]     r_ptr;
    logic [IW-1:0]     r_gid;
    logic              r_data;
    logic              r_dv;
    logic              r_wd;

    logic [N_REQ-1:0]  w_gnt;
    logic [IW-1:0]     w_idx;
    logic              w_any;
    logic              w_take;
    logic              w_last;
    logic [WORD_W-1:0] w_word;

    rr_arbiter_comb #(.N_REQ(N_REQ), .IW(IW)) u_arb (
        .i_vld (bus.REQ_VALID),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    // Qualified by RST so no requester sees an accept while reset is held.
    assign w_take = (r_state == IDLE) && w_any && !bus.ABORT && RST;
    assign w_word = bus.REQ_WORD[w_idx*WORD_W +: WORD_W];
    assign w_last = (r_cnt == CW'(WORD_W - 1));

    assign bus.REQ_READY  = w_gnt & {N_REQ{w_take}};
    assign bus.DATA       = r_data;
    assign bus.DATA_VALID = r_dv;
    assign bus.GRANT_ID   = r_gid;
    assign bus.BUSY       = (r_state != IDLE);
    assign bus.WORD_DONE  = r_wd;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= IDLE;
            r_shreg <= '0;
            r_cnt   <= '0;
            r_gap   <= '0;
            r_ptr   <= IW'(N_REQ - 1);
            r_gid   <= '0;
            r_data  <= 1'b0;
            r_dv    <= 1'b0;
            r_wd    <= 1'b0;
        end else begin
            r_wd <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_take) begin
                        r_data  <= w_word[0];
                        r_shreg <= w_word >> 1;
                        r_dv    <= 1'b1;
                        r_cnt   <= '0;
                        r_ptr   <= w_idx;
                        r_gid   <= w_idx;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bus.ABORT) begin
                        r_data  <= 1'b0;
                        r_dv    <= 1'b0;
                        r_state <= IDLE;
                    end else if (w_last) begin
                        r_data <= 1'b0;
                        r_dv   <= 1'b0;
                        r_wd   <= 1'b1;
                        r_gap  <= '0;
                        if (GAP_CYCLES == 0) r_state <= IDLE;
                        else                 r_state <= GAP;
                    end else begin
                        r_data  <= r_shreg[0];
                        r_shreg <= r_shreg >> 1;
                        r_cnt   <= r_cnt + CW'(1);
                    end
                end
                GAP: begin
                    if (bus.ABORT || (32'(r_gap) == 32'(GAP_CYCLES - 1))) r_state <= IDLE;
                    else r_gap <= r_gap + GW'(1);
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef SEQ_SCHED_DET_COUNT_EN
    localparam int DC_W = $clog2(WORD_W + 2);

    logic [DC_W-1:0] r_det_acc;
    logic [DC_W-1:0] r_det_cnt;

    // The detector answers one cycle late, so the WORD_DONE cycle's DET_IN is folded into the load.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_det_acc <= '0;
            r_det_cnt <= '0;
        end else begin
            if (w_take)                               r_det_acc <= '0;
            else if (r_state == SHIFT && bus.DET_IN)  r_det_acc <= r_det_acc + DC_W'(1);
            if (r_wd)                                 r_det_cnt <= r_det_acc + DC_W'(bus.DET_IN);
        end
    end

    assign bus.DET_COUNT = r_det_cnt;
`endif
endmodule
